aht10_i2c_target: RTL and testbench

//   I2C target (responder) that emulates the AHT10 sensor on the bus: address match, command decode
//   (init / trigger / soft reset), busy timing and the 6-byte measurement read-back.

---
 rtl/aht10_pkg.sv | 33 +++
 rtl/i2c_bus_sync.sv | 45 ++++
 rtl/aht10_i2c_target.sv | 245 ++++++++++++++++++++++++
 tb/tb_aht10_i2c_target.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aht10_pkg.sv
// Shared constants and types for the AHT10 target emulation:
// bus address, command opcodes, status bit layout and the bus FSM states.
package aht10_pkg;

    localparam logic [6:0] AHT10_ADDR = 7'h38;

    localparam logic [7:0] CMD_INIT = 8'hE1;
    localparam logic [7:0] CMD_TRIG = 8'hAC;
    localparam logic [7:0] CMD_SRST = 8'hBA;

    localparam int STAT_BUSY_BIT = 7;
    localparam int STAT_CAL_BIT  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } aht10_state_e;

    function automatic logic [7:0] status_byte(input logic busy, input logic cal);
        logic [7:0] s;
        s = '0;
        s[STAT_BUSY_BIT] = busy;
        s[STAT_CAL_BIT]  = cal;
        return s;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises the asynchronous SCL/SDA pads into clk and derives
// single-cycle SCL edge strobes plus START/STOP condition strobes.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_async,
    input  logic sda_async,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sr;
    logic [SYNC_STAGES-1:0] sda_sr;
    logic                   scl_q;
    logic                   sda_q;
    logic                   scl_s;

    // Idle bus level is high, so the chains reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_sr <= (scl_sr << 1) | SYNC_STAGES'(scl_async);
            sda_sr <= (sda_sr << 1) | SYNC_STAGES'(sda_async);
            scl_q  <= scl_s;
            sda_q  <= sda_s;
        end
    end

    assign scl_s    = scl_sr[SYNC_STAGES-1];
    assign sda_s    = sda_sr[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    assign start    = scl_s & scl_q & sda_q & ~sda_s;
    assign stop     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/aht10_i2c_target.sv
// AHT10 sensor emulation on an I2C bus: address match, write-command decode,
// measurement busy timer with snapshot, and 6-byte status/data read-back.
module aht10_i2c_target
    import aht10_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = AHT10_ADDR,
    parameter int         MEAS_CYCLES = 3_750_000,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i2c_scl,
    input  logic        i2c_sda_i,
    output logic        i2c_sda_o,
    output logic        i2c_sda_oe,
    input  logic [19:0] hum_data,
    input  logic [19:0] temp_data,
    output logic        busy,
    output logic        cal_en,
    output logic        meas_done
);

    localparam int CW = (MEAS_CYCLES > 1) ? $clog2(MEAS_CYCLES) : 1;

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_async (i2c_scl),
        .sda_async (i2c_sda_i),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start     (start),
        .stop      (stop)
    );

    aht10_state_e state, state_nx;
    logic [3:0]   bit_cnt, bit_cnt_nx;
    logic [7:0]   rx_sh, rx_nx;
    logic [7:0]   tx_sh, tx_nx;
    logic         oe_nx;
    logic [1:0]   wr_idx, wr_idx_nx;
    logic [2:0]   wr_cnt, wr_cnt_nx;
    logic         wr_frame, wr_frame_nx;
    logic [2:0]   rd_idx, rd_idx_nx;
    logic         buf_we;
    logic         cmd_stop;
    logic [7:0]   wr_buf [4];

    logic [CW-1:0] meas_cnt, cnt_nx;
    logic          busy_nx, cal_nx, expire;
    logic [19:0]   snap_hum, snap_temp;
    logic [2:0]    rd_sel;
    logic [7:0]    rd_byte;

    assign i2c_sda_o = 1'b0;

    // Byte 0 is always the live status; later bytes come from the snapshot.
    assign rd_sel = (state == ST_ADDR_ACK) ? 3'd0 : rd_idx;

    always_comb begin
        case (rd_sel)
            3'd0:    rd_byte = status_byte(busy, cal_en);
            3'd1:    rd_byte = snap_hum[19:12];
            3'd2:    rd_byte = snap_hum[11:4];
            3'd3:    rd_byte = {snap_hum[3:0], snap_temp[19:16]};
            3'd4:    rd_byte = snap_temp[15:8];
            3'd5:    rd_byte = snap_temp[7:0];
            default: rd_byte = 8'hFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            i2c_sda_oe <= 1'b0;
            wr_idx     <= '0;
            wr_cnt     <= '0;
            wr_frame   <= 1'b0;
            rd_idx     <= '0;
            for (int i = 0; i < 4; i++) wr_buf[i] <= '0;
        end else begin
            state      <= state_nx;
            bit_cnt    <= bit_cnt_nx;
            rx_sh      <= rx_nx;
            tx_sh      <= tx_nx;
            i2c_sda_oe <= oe_nx;
            wr_idx     <= wr_idx_nx;
            wr_cnt     <= wr_cnt_nx;
            wr_frame   <= wr_frame_nx;
            rd_idx     <= rd_idx_nx;
            if (buf_we) wr_buf[wr_idx] <= rx_sh;
        end
    end

    // Bus FSM. SDA drive only moves on scl_fall, except START/STOP which release it.
    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        rx_nx       = rx_sh;
        tx_nx       = tx_sh;
        oe_nx       = i2c_sda_oe;
        wr_idx_nx   = wr_idx;
        wr_cnt_nx   = wr_cnt;
        wr_frame_nx = wr_frame;
        rd_idx_nx   = rd_idx;
        buf_we      = 1'b0;
        cmd_stop    = 1'b0;

        if (stop) begin
            state_nx    = ST_IDLE;
            oe_nx       = 1'b0;
            cmd_stop    = wr_frame;
            wr_frame_nx = 1'b0;
        end else if (start) begin
            state_nx    = ST_ADDR;
            bit_cnt_nx  = '0;
            oe_nx       = 1'b0;
            wr_frame_nx = 1'b0;
        end else begin
            case (state)
                ST_ADDR: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        rx_nx      = {rx_sh[6:0], sda_s};
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (rx_sh[7:1] == SLAVE_ADDR) begin
                            state_nx = ST_ADDR_ACK;
                            oe_nx    = 1'b1;
                        end else begin
                            state_nx = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_nx = '0;
                        if (rx_sh[0]) begin
                            state_nx  = ST_RD_BYTE;
                            tx_nx     = rd_byte;
                            oe_nx     = ~rd_byte[7];
                            rd_idx_nx = 3'd1;
                        end else begin
                            state_nx    = ST_WR_BYTE;
                            oe_nx       = 1'b0;
                            wr_idx_nx   = '0;
                            wr_cnt_nx   = '0;
                            wr_frame_nx = 1'b1;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        rx_nx      = {rx_sh[6:0], sda_s};
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        buf_we   = 1'b1;
                        state_nx = ST_WR_ACK;
                        oe_nx    = 1'b1;
                        if (wr_idx != 2'd3) wr_idx_nx = wr_idx + 2'd1;
                        if (wr_cnt != 3'd7) wr_cnt_nx = wr_cnt + 3'd1;
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        state_nx   = ST_WR_BYTE;
                        oe_nx      = 1'b0;
                        bit_cnt_nx = '0;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        state_nx = ST_RD_ACK;
                        oe_nx    = 1'b0;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        tx_nx = {tx_sh[6:0], 1'b0};
                        oe_nx = ~tx_sh[6];
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise && sda_s) begin
                        state_nx = ST_IGNORE;
                    end else if (scl_fall) begin
                        state_nx   = ST_RD_BYTE;
                        tx_nx      = rd_byte;
                        oe_nx      = ~rd_byte[7];
                        bit_cnt_nx = '0;
                        if (rd_idx < 3'd6) rd_idx_nx = rd_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Measurement timer: expiry is resolved before any command arriving in the same cycle.
    always_comb begin
        expire  = busy && (meas_cnt == '0);
        busy_nx = busy && !expire;
        cnt_nx  = (busy && !expire) ? meas_cnt - 1'b1 : meas_cnt;
        cal_nx  = cal_en;
        if (cmd_stop) begin
            if (wr_buf[0] == CMD_INIT && wr_cnt == 3'd3) begin
                cal_nx = 1'b1;
            end else if (wr_buf[0] == CMD_TRIG && wr_cnt == 3'd3) begin
                if (!busy_nx) begin
                    busy_nx = 1'b1;
                    cnt_nx  = CW'(MEAS_CYCLES - 1);
                end
            end else if (wr_buf[0] == CMD_SRST && wr_cnt == 3'd1) begin
                cal_nx  = 1'b0;
                busy_nx = 1'b0;
                cnt_nx  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            cal_en    <= 1'b0;
            meas_cnt  <= '0;
            meas_done <= 1'b0;
            snap_hum  <= '0;
            snap_temp <= '0;
        end else begin
            busy      <= busy_nx;
            cal_en    <= cal_nx;
            meas_cnt  <= cnt_nx;
            meas_done <= expire;
            if (expire) begin
                snap_hum  <= hum_data;
                snap_temp <= temp_data;
            end
        end
    end

endmodule

// File: tb/tb_aht10_i2c_target.sv
// Directed bench for aht10_i2c_target: a bit-banged I2C master drives the bus,
// read-back bytes are checked against a scoreboard queue of expected values.
module tb_aht10_i2c_target;

    localparam int Q = 4;  // clk cycles per quarter SCL period

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic [19:0] hum = '0;
    logic [19:0] temp = '0;
    logic        i2c_sda_o, i2c_sda_oe, busy, cal_en, meas_done;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    int   busy_cycles = 0;
    int   done_pulses = 0;
    logic cnt_clr = 1'b0;

    assign sda_bus = sda_m & ~i2c_sda_oe;

    always #5 clk = ~clk;

    aht10_i2c_target #(
        .SLAVE_ADDR  (7'h38),
        .MEAS_CYCLES (200),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i2c_scl    (scl_m),
        .i2c_sda_i  (sda_bus),
        .i2c_sda_o  (i2c_sda_o),
        .i2c_sda_oe (i2c_sda_oe),
        .hum_data   (hum),
        .temp_data  (temp),
        .busy       (busy),
        .cal_en     (cal_en),
        .meas_done  (meas_done)
    );

    always @(negedge clk) begin
        if (cnt_clr) begin
            busy_cycles = 0;
            done_pulses = 0;
        end else begin
            if (busy) busy_cycles = busy_cycles + 1;
            if (meas_done) done_pulses = done_pulses + 1;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq(); wq();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        b = sda_bus; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        d = '0;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    // Write frame to 0x70; every byte must be ACKed low.
    task automatic write_cmd(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input int n);
        logic ack;
        logic [7:0] bytes [3];
        bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
        i2c_start();
        write_byte(8'h70, ack);
        check({tag, "_addr_ack"}, ack, 1'b0);
        for (int k = 0; k < n; k++) begin
            write_byte(bytes[k], ack);
            check({tag, "_data_ack"}, ack, 1'b0);
        end
        i2c_stop();
    endtask

    // Read n bytes from 0x71, comparing each against the scoreboard; last byte NACKed.
    task automatic read_frame(input string tag, input int n, input logic do_stop);
        logic ack;
        logic [7:0] d;
        i2c_start();
        write_byte(8'h71, ack);
        check({tag, "_addr_ack"}, ack, 1'b0);
        for (int k = 0; k < n; k++) begin
            read_byte(d, (k == n - 1));
            check({tag, "_sb_nonempty"}, (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) check({tag, "_rd_byte"}, d, exp_q.pop_front());
        end
        if (do_stop) i2c_stop();
    endtask

    initial begin
        logic ack;
        logic [7:0] d;
        int waited;

        // reset state
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_sda_oe", i2c_sda_oe, 1'b0);
        check("rst_sda_o", i2c_sda_o, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_cal_en", cal_en, 1'b0);
        check("rst_meas_done", meas_done, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // init command sets calibration flag
        write_cmd("init", 8'hE1, 8'h08, 8'h00, 3);
        check("init_cal_en", cal_en, 1'b1);
        exp_q.push_back(8'h08);
        read_frame("init_status", 1, 1'b1);

        // trigger: busy window, status during/after, meas_done pulse
        hum  = 20'hABCDE;
        temp = 20'h12345;
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        write_cmd("trig", 8'hAC, 8'h33, 8'h00, 3);
        check("trig_busy_set", busy, 1'b1);
        exp_q.push_back(8'h88);
        read_frame("trig_status_busy", 1, 1'b1);
        waited = 0;
        while (busy && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        check("trig_busy_timeout", (waited < 1000), 1'b1);
        repeat (4) @(negedge clk);
        check("trig_busy_cycles", busy_cycles, 200);
        check("trig_done_pulses", done_pulses, 1);
        check("trig_meas_done_low", meas_done, 1'b0);

        // full read-back incl. byte past the end
        exp_q.push_back(8'h08);
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'hE1);
        exp_q.push_back(8'h23);
        exp_q.push_back(8'h45);
        exp_q.push_back(8'hFF);
        read_frame("data", 7, 1'b0);
        repeat (4) @(negedge clk);
        check("data_nack_release", i2c_sda_oe, 1'b0);
        i2c_stop();

        // foreign address is not ACKed and changes nothing
        i2c_start();
        write_byte(8'h72, ack);
        check("bad_addr_nack", ack, 1'b1);
        write_byte(8'hBA, ack);
        check("bad_addr_data_nack", ack, 1'b1);
        i2c_stop();
        check("bad_addr_cal_en", cal_en, 1'b1);
        check("bad_addr_busy", busy, 1'b0);
        exp_q.push_back(8'h08);
        read_frame("after_bad", 1, 1'b1);

        // repeated START mid-read restarts at the status byte
        exp_q.push_back(8'h08);
        exp_q.push_back(8'hAB);
        i2c_start();
        write_byte(8'h71, ack);
        check("rs_addr_ack", ack, 1'b0);
        for (int k = 0; k < 2; k++) begin
            read_byte(d, 1'b0);
            check("rs_sb_nonempty", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) check("rs_rd_byte", d, exp_q.pop_front());
        end
        exp_q.push_back(8'h08);
        read_frame("rs_restart", 1, 1'b1);

        // soft reset clears flags but keeps the snapshot
        write_cmd("srst", 8'hBA, 8'h00, 8'h00, 1);
        check("srst_cal_en", cal_en, 1'b0);
        check("srst_busy", busy, 1'b0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hAB);
        read_frame("srst_read", 2, 1'b1);

        // bus reset mid read while driving SDA low
        write_cmd("init2", 8'hE1, 8'h08, 8'h00, 3);
        check("init2_cal_en", cal_en, 1'b1);
        i2c_start();
        write_byte(8'h71, ack);
        check("rstmid_addr_ack", ack, 1'b0);
        repeat (2) @(negedge clk);
        check("rstmid_oe_before", i2c_sda_oe, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_oe_after", i2c_sda_oe, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_cal_en", cal_en, 1'b0);
        rst = 1'b0;
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq(); wq();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        read_frame("post_rst", 3, 1'b1);

        check("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
